// File: rtl/alu_pkg.sv
// Shared opcode definitions and per-bit gate evaluation for the bitwise ALU path.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND    = 4'd0;
  localparam logic [OP_W-1:0] OP_NAND   = 4'd1;
  localparam logic [OP_W-1:0] OP_OR     = 4'd2;
  localparam logic [OP_W-1:0] OP_NOR    = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR    = 4'd4;
  localparam logic [OP_W-1:0] OP_XNOR   = 4'd5;
  localparam logic [OP_W-1:0] OP_NOT_A  = 4'd6;
  localparam logic [OP_W-1:0] OP_PASS_A = 4'd7;

  // Anything past PASS_A is reserved and reported as an error.
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return (op > OP_PASS_A);
  endfunction

  function automatic logic gate_bit(input logic [OP_W-1:0] op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:    r = a & b;
      OP_NAND:   r = ~(a & b);
      OP_OR:     r = a | b;
      OP_NOR:    r = ~(a | b);
      OP_XOR:    r = a ^ b;
      OP_XNOR:   r = ~(a ^ b);
      OP_NOT_A:  r = ~a;
      OP_PASS_A: r = a;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_logic_core.sv
// Combinational bitwise gate bank: op/a/b -> y/err. Illegal opcodes force y to zero.
module alu_logic_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  assign err = op_illegal(op);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign y[gi] = err ? 1'b0 : gate_bit(op, a[gi], b[gi]);
    end
  endgenerate

endmodule

// File: rtl/alu_logic_pipe.sv
// Two-stage valid/ready pipeline around alu_logic_core with zero/error flags.
// Optional parity output enabled by defining ALU_LOGIC_PARITY_EN.
module alu_logic_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_err
`ifdef ALU_LOGIC_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]  s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_y_q, s2_y_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_err_q, s2_err_d;
`ifdef ALU_LOGIC_PARITY_EN
  logic             s2_par_q, s2_par_d;
`endif

  logic             s2_accept;
  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] core_y;
  logic             core_err;

  // S2 frees up either when empty or when downstream takes its result this edge.
  assign s2_accept = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_accept;
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_valid_q && s2_accept;

  alu_logic_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op  (s1_op_q),
    .a   (s1_a_q),
    .b   (s1_b_q),
    .y   (core_y),
    .err (core_err)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    s2_y_d     = s2_y_q;
    s2_zero_d  = s2_zero_q;
    s2_err_d   = s2_err_q;
`ifdef ALU_LOGIC_PARITY_EN
    s2_par_d   = s2_par_q;
`endif

    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_accept) begin
      s2_valid_d = s1_valid_q;
    end

    if (s2_load) begin
      s2_y_d    = core_y;
      s2_zero_d = (core_y == '0);
      s2_err_d  = core_err;
`ifdef ALU_LOGIC_PARITY_EN
      s2_par_d  = ^core_y;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_zero_q  <= 1'b0;
      s2_err_q   <= 1'b0;
`ifdef ALU_LOGIC_PARITY_EN
      s2_par_q   <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_y_q     <= s2_y_d;
      s2_zero_q  <= s2_zero_d;
      s2_err_q   <= s2_err_d;
`ifdef ALU_LOGIC_PARITY_EN
      s2_par_q   <= s2_par_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign out_y     = s2_y_q;
  assign out_zero  = s2_zero_q;
  assign out_err   = s2_err_q;
`ifdef ALU_LOGIC_PARITY_EN
  assign out_par   = s2_par_q;
`endif

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Self-checking bench for alu_logic_pipe (WIDTH=8) with a queue-based reference model.
module tb_alu_logic_pipe;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] y;
    logic         zero;
    logic         err;
    logic         par;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic         out_zero;
  logic         out_err;
`ifdef ALU_LOGIC_PARITY_EN
  logic         out_par;
`endif

  int   checks;
  int   failures;
  res_t exp_q[$];

  alu_logic_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero),
    .out_err   (out_err)
`ifdef ALU_LOGIC_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour written straight from the opcode table.
  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    r.err = 1'b0;
    case (op)
      4'd0:    r.y = a & b;
      4'd1:    r.y = ~(a & b);
      4'd2:    r.y = a | b;
      4'd3:    r.y = ~(a | b);
      4'd4:    r.y = a ^ b;
      4'd5:    r.y = ~(a ^ b);
      4'd6:    r.y = ~a;
      4'd7:    r.y = a;
      default: begin r.y = '0; r.err = 1'b1; end
    endcase
    r.zero = (r.y == 0);
`ifdef ALU_LOGIC_PARITY_EN
    r.par = r.err ? 1'b0 : ^r.y;
`else
    r.par = 1'b0;
`endif
    return r;
  endfunction

  // One clock of stimulus: samples outputs, drives inputs, logs accepted ops into the model queue.
  task automatic tick(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ordy, output logic got, output logic acc, output logic ird, output res_t obs);
    @(negedge clk);
    obs.y    = out_y;
    obs.zero = out_zero;
    obs.err  = out_err;
`ifdef ALU_LOGIC_PARITY_EN
    obs.par  = out_par;
`else
    obs.par  = 1'b0;
`endif
    out_ready = ordy;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    #1;
    got = out_valid && ordy;
    ird = in_ready;
    acc = v && in_ready;
    if (acc) exp_q.push_back(model(op, a, b));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_y !== 8'h00 || out_zero !== 1'b0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got v=%b y=%h z=%b e=%b want v=0 y=00 z=0 e=0", out_valid, out_y, out_zero, out_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_ops();
    logic [W-1:0] tbl [8];
    logic got, acc, ird;
    res_t obs, e;
    int t, first_acc, n;
    tbl = '{8'hC0, 8'h3F, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    first_acc = -1; n = 0;
    for (t = 0; t < 20 && n < 8; t++) begin
      if (t < 8) tick(1'b1, t[3:0], 8'hF0, 8'hCC, 1'b1, got, acc, ird, obs);
      else       tick(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, got, acc, ird, obs);
      if (acc && first_acc < 0) first_acc = t;
      if (got) begin
        e = exp_q.pop_front();
        checks++;
        if (obs.y !== tbl[n] || obs !== e || t !== first_acc + 2 + n) begin
          failures++;
          $display("FAIL basic_op%0d got y=%h z=%b e=%b cyc=%0d want y=%h z=%b e=%b cyc=%0d",
                   n, obs.y, obs.zero, obs.err, t, tbl[n], e.zero, e.err, first_acc + 2 + n);
        end
        $display("basic op=%0d y=%h", n, obs.y);
        n++;
      end
    end
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL basic_count got %0d want 8", n);
    end
  endtask

  task automatic test_flags();
    logic got, acc, ird;
    res_t obs, e;
    int n;
    n = 0;
    tick(1'b1, 4'hA, 8'h55, 8'hAA, 1'b1, got, acc, ird, obs);
    tick(1'b1, 4'h1, 8'hFF, 8'hFF, 1'b1, got, acc, ird, obs);
    for (int t = 0; t < 10 && n < 2; t++) begin
      tick(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, got, acc, ird, obs);
      if (got) begin
        e = exp_q.pop_front();
        checks++;
        if (obs.y !== 8'h00 || obs.zero !== 1'b1 || obs.err !== (n == 0) || obs !== e) begin
          failures++;
          $display("FAIL flags%0d got y=%h z=%b e=%b want y=00 z=1 e=%b", n, obs.y, obs.zero, obs.err, (n == 0));
        end
        $display("flags case=%0d y=%h z=%b e=%b", n, obs.y, obs.zero, obs.err);
        n++;
      end
    end
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL flags_count got %0d want 2", n);
    end
  endtask

  task automatic test_backpressure();
    logic got, acc, ird, sent;
    res_t obs, e;
    logic [3:0] ops [3];
    logic [W-1:0] as [3];
    int nacc, n;
    ops = '{4'd0, 4'd4, 4'd6};
    as  = '{8'h5A, 8'h3C, 8'h81};
    nacc = 0; n = 0;
    tick(1'b1, ops[0], as[0], 8'h96, 1'b0, got, acc, ird, obs);
    if (acc) nacc++;
    tick(1'b1, ops[1], as[1], 8'h96, 1'b0, got, acc, ird, obs);
    if (acc) nacc++;
    checks++;
    if (nacc !== 2) begin
      failures++;
      $display("FAIL bp_accepted got %0d want 2", nacc);
    end
    for (int t = 0; t < 3; t++) begin
      tick(1'b1, ops[2], as[2], 8'h96, 1'b0, got, acc, ird, obs);
      checks++;
      if (ird !== 1'b0 || out_valid !== 1'b1 || exp_q.size() == 0 || obs.y !== exp_q[0].y) begin
        failures++;
        $display("FAIL bp_stall t=%0d got rdy=%b v=%b y=%h want rdy=0 v=1 y=%h",
                 t, ird, out_valid, obs.y, (exp_q.size() > 0) ? exp_q[0].y : 8'hxx);
      end
      $display("bp stall t=%0d in_ready=%b y=%h", t, ird, obs.y);
    end
    sent = 1'b0;
    for (int t = 0; t < 20 && n < 3; t++) begin
      tick(!sent, ops[2], as[2], 8'h96, 1'b1, got, acc, ird, obs);
      if (acc) sent = 1'b1;
      if (got) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e || e !== model(ops[n], as[n], 8'h96)) begin
          failures++;
          $display("FAIL bp_result%0d got y=%h z=%b e=%b want y=%h", n, obs.y, obs.zero, obs.err, e.y);
        end
        $display("bp result=%0d y=%h", n, obs.y);
        n++;
      end
    end
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL bp_count got %0d want 3", n);
    end
  endtask

  task automatic test_back_to_back();
    logic got, acc, ird;
    res_t obs, e;
    int n;
    n = 0;
    tick(1'b1, 4'd2, 8'h11, 8'h22, 1'b0, got, acc, ird, obs);
    tick(1'b1, 4'd3, 8'h44, 8'h08, 1'b0, got, acc, ird, obs);
    for (int t = 0; t < 4; t++) begin
      tick(1'b1, 4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b1, got, acc, ird, obs);
      checks++;
      if (ird !== 1'b1 || got !== 1'b1) begin
        failures++;
        $display("FAIL b2b_flow t=%0d got in_ready=%b out_valid=%b want 1 1", t, ird, got);
      end
      if (got) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL b2b_result t=%0d got y=%h want y=%h", t, obs.y, e.y);
        end
        $display("b2b t=%0d y=%h", t, obs.y);
        n++;
      end
    end
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) begin
      tick(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, got, acc, ird, obs);
      if (got) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL b2b_drain got y=%h want y=%h", obs.y, e.y);
        end
        n++;
      end
    end
    checks++;
    if (n !== 6) begin
      failures++;
      $display("FAIL b2b_count got %0d want 6", n);
    end
  endtask

  task automatic test_reset_midflight();
    logic got, acc, ird;
    res_t obs;
    int stale;
    tick(1'b1, 4'd7, 8'hA5, 8'h00, 1'b1, got, acc, ird, obs);
    tick(1'b1, 4'd7, 8'h5A, 8'h00, 1'b1, got, acc, ird, obs);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0 || out_y !== 8'h00 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_state got v=%b y=%h rdy=%b want v=0 y=00 rdy=1", out_valid, out_y, in_ready);
    end
    stale = 0;
    for (int t = 0; t < 5; t++) begin
      tick(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, got, acc, ird, obs);
      if (got) stale++;
    end
    checks++;
    if (stale !== 0) begin
      failures++;
      $display("FAIL midrst_stale got %0d results want 0", stale);
    end
    $display("midflight reset stale=%0d", stale);
  endtask

  task automatic test_random();
    logic got, acc, ird;
    res_t obs, e;
    int n;
    n = 0;
    for (int t = 0; t < 400; t++) begin
      tick(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 9) < 7), got, acc, ird, obs);
      if (got) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra got y=%h with no outstanding op", obs.y);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            failures++;
            $display("FAIL rand_result%0d got y=%h z=%b e=%b p=%b want y=%h z=%b e=%b p=%b",
                     n, obs.y, obs.zero, obs.err, obs.par, e.y, e.zero, e.err, e.par);
          end
        end
        n++;
      end
    end
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) begin
      tick(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, got, acc, ird, obs);
      if (got) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL rand_drain got y=%h want y=%h", obs.y, e.y);
        end
        n++;
      end
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL rand_lost got %0d outstanding want 0", exp_q.size());
    end
    $display("random results=%0d", n);
  endtask

`ifdef ALU_LOGIC_PARITY_EN
  task automatic test_parity();
    logic got, acc, ird;
    res_t obs;
    logic want [2];
    int n;
    want = '{1'b1, 1'b0};
    n = 0;
    tick(1'b1, 4'd7, 8'h07, 8'h00, 1'b1, got, acc, ird, obs);
    tick(1'b1, 4'd7, 8'h03, 8'h00, 1'b1, got, acc, ird, obs);
    for (int t = 0; t < 10 && n < 2; t++) begin
      tick(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, got, acc, ird, obs);
      if (got) begin
        void'(exp_q.pop_front());
        checks++;
        if (obs.par !== want[n]) begin
          failures++;
          $display("FAIL parity%0d got %b want %b", n, obs.par, want[n]);
        end
        $display("parity case=%0d par=%b", n, obs.par);
        n++;
      end
    end
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL parity_count got %0d want 2", n);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic_ops();
    test_flags();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
`ifdef ALU_LOGIC_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_logic_pipe.md
Name: alu_logic_pipe

Overview:
- Registered front end for the ALU's bitwise gate bank (AND/NAND/OR/NOR/XOR/XNOR/NOT/PASS).
- Accepts operand pairs plus an opcode over a valid/ready handshake and evaluates them through a two-stage pipeline.
- Presents the registered result, with zero and error flags, to the downstream result-writeback stage.
- Throughput is one operation per cycle when not stalled.

Parameters:
- WIDTH, 8, operand and result bit width (1..64).

Ports:
- clk  input  1  single clock; rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  upstream has a valid operation.
- in_ready  output  1  block can accept an operation this cycle.
- in_op  input  4  opcode, see Behaviour.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- out_y  output  WIDTH  result.
- out_zero  output  1  out_y == 0.
- out_err  output  1  opcode was illegal.

Behaviour:
- Reset: rst_n low at a rising edge clears both stage valids, all data registers, out_y, out_zero and out_err to 0. in_ready reads 1 the cycle after reset deasserts. Reset asserted mid-operation discards all in-flight operations; nothing is replayed.
- Opcodes (alu_pkg):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A (~a, b ignored), 7 PASS_A.
  - 8..15 illegal: y=0, err=1, zero=1.
- Stage 1 (S1): captures in_op, in_a, in_b when in_valid && in_ready.
- Stage 2 (S2): captures the core result plus flags from S1 when S1 is valid and S2 can accept.
- Advance rules:
  - s2_accept = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_accept; combinational, no dependence on in_valid.
- Latency: an operation accepted at edge N is visible on the outputs after edge N+2 when unstalled.
- Stall: out_valid && !out_ready holds out_y and flags stable. S1 holds. in_ready drops once S1 is also full.
- Simultaneous events: with both stages full, out_ready=1 and in_valid=1, S2 takes S1 and S1 takes the new input in the same edge, with no bubble.
- Drain: when no input is accepted, S1 valid clears as S1 moves into S2.
- Ordering is strictly FIFO; no reordering and no drops.
- Outputs are stable while out_valid=1 and out_ready=0. Inputs may change freely while in_ready=0.
- Width: results are exactly WIDTH bits; no carry or extension.

Optional Feature:
- Macro: ALU_LOGIC_PARITY_EN.
- Defined: adds output out_par (1 bit) = XOR-reduce of out_y, registered in S2 alongside out_zero. It resets to 0 and is 0 for illegal opcodes.
- Undefined: port absent; no parity logic.

Decomposition:
- alu_pkg holds:
  - opcode localparams OP_AND..OP_PASS_A;
  - OP_W=4;
  - a function or constant marking opcodes >= 8 as illegal.
- Sub-module alu_logic_core: purely combinational op/a/b -> y/err, instanced between S1 and S2.
- The existing gate modules may be instanced inside alu_logic_core. The pipe holds only handshake and registers.

Test Plan (WIDTH=8):
- Basic ops: a=8'hF0, b=8'hCC, ops 0..7 back-to-back with out_ready=1. Results are C0, 3F, FC, 03, 3C, C3, 0F, F0 in order. First out_valid comes 2 cycles after the first accept, then one per cycle.
- Illegal and zero flags:
  - op=4'hA, a=8'h55, b=8'hAA -> out_y=00, out_err=1, out_zero=1.
  - op=1 (NAND), a=8'hFF, b=8'hFF -> out_y=00, out_zero=1, out_err=0.
- Backpressure: hold out_ready=0 and issue 3 ops. Two are accepted, then in_ready=0, and out_y stays stable. Raise out_ready: all 3 results emerge in order and none are lost.
- Full-pipe simultaneous move: both stages full, out_ready=1, in_valid=1 for 4 cycles. in_ready stays 1 and there are 4 consecutive out_valid cycles with no bubble.
- Reset mid-flight: 2 ops in flight, drive rst_n=0 for 1 cycle. Next cycle out_valid=0, out_y=00, in_ready=1, and no stale result appears afterwards.
- Parity (ALU_LOGIC_PARITY_EN): op=7, a=8'h07 -> out_par=1; a=8'h03 -> out_par=0.
